// File: rtl/fifo_wr_packer.sv
// Write-side width packer: gathers RATIO narrow beats, LSB lane first, into one FIFO word
// and pushes it into the FIFO write port through a single holding slot.
module fifo_wr_packer #(
    parameter int unsigned IN_WIDTH  = 1,
    parameter int unsigned RATIO     = 4,
    parameter logic        PAD_BIT   = 1'b0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                                wr_clk,
    input  logic                                wr_rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [IN_WIDTH-1:0]                 s_data,
    input  logic                                s_last,
    input  logic                                flush,
    output logic                                fifo_wr_en,
    output logic [IN_WIDTH*RATIO-1:0]           fifo_wr_data,
    input  logic                                fifo_full,
    output logic [$clog2(RATIO)-1:0]            lane_idx,
    output logic [CNT_WIDTH-1:0]                frame_cnt
);

    localparam int unsigned DATA_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned LANE_W     = $clog2(RATIO);

    typedef logic [LANE_W-1:0] lane_t;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    lane_t                 lane_q, lane_d;
    logic [DATA_WIDTH-1:0] out_word_q, out_word_d;
    logic                  out_last_q, out_last_d;
    logic                  out_vld_q, out_vld_d;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;

    logic                  take;
    logic                  accept;
    logic                  lane_full;
    logic                  close;
    logic [DATA_WIDTH-1:0] closed_word;

    assign take         = out_vld_q && !fifo_full;
    assign s_ready      = !out_vld_q || take;
    assign accept       = s_valid && s_ready;
    assign lane_full    = (lane_q == lane_t'(RATIO - 1));
    assign fifo_wr_en   = take;
    assign fifo_wr_data = out_word_q;
    assign lane_idx     = lane_q;
    assign frame_cnt    = frame_cnt_q;

    // A flush without a beat only closes when lanes are pending and the slot can take the word.
    assign close = (accept && (lane_full || s_last || flush)) ||
                   (flush && (lane_q != '0) && s_ready);

    // Lanes below lane_q come from acc, the current lane from the new beat, the rest are padded.
    always_comb begin
        closed_word = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_t'(i) < lane_q) begin
                closed_word[i*IN_WIDTH +: IN_WIDTH] = acc_q[i*IN_WIDTH +: IN_WIDTH];
            end else if (accept && (lane_t'(i) == lane_q)) begin
                closed_word[i*IN_WIDTH +: IN_WIDTH] = s_data;
            end else begin
                closed_word[i*IN_WIDTH +: IN_WIDTH] = {IN_WIDTH{PAD_BIT}};
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        lane_d      = lane_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        out_vld_d   = out_vld_q;
        frame_cnt_d = frame_cnt_q;

        if (take) begin
            out_vld_d = 1'b0;
            if (out_last_q) begin
                frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
            end
        end

        if (close) begin
            out_word_d = closed_word;
            out_last_d = accept && s_last;
            out_vld_d  = 1'b1;
            acc_d      = '0;
            lane_d     = '0;
        end else if (accept) begin
            acc_d[lane_q*IN_WIDTH +: IN_WIDTH] = s_data;
            lane_d = lane_q + lane_t'(1);
        end
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            acc_q       <= '0;
            lane_q      <= '0;
            out_word_q  <= '0;
            out_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            acc_q       <= acc_d;
            lane_q      <= lane_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            out_vld_q   <= out_vld_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed self-checking bench for fifo_wr_packer (IN_WIDTH=1, RATIO=4, PAD_BIT=0).
module tb_fifo_wr_packer;

    logic        wr_clk;
    logic        wr_rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [0:0]  s_data;
    logic        s_last;
    logic        flush;
    logic        fifo_wr_en;
    logic [3:0]  fifo_wr_data;
    logic        fifo_full;
    logic [1:0]  lane_idx;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    fifo_wr_packer #(
        .IN_WIDTH (1),
        .RATIO    (4),
        .PAD_BIT  (1'b0),
        .CNT_WIDTH(16)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst_n    (wr_rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .flush       (flush),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full   (fifo_full),
        .lane_idx    (lane_idx),
        .frame_cnt   (frame_cnt)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Inputs change on the falling edge; the rising edge commits them.
    task automatic step();
        @(posedge wr_clk);
        @(negedge wr_clk);
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_data  = 1'b0;
        s_last  = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic send_beat(input logic d, input logic last, input logic fl);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        flush   = fl;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        wr_rst_n  = 1'b0;
        fifo_full = 1'b0;
        idle_inputs();
        step();
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || fifo_wr_data !== 4'b0000) begin
            failures++;
            $display("FAIL reset_wr: en=%b data=%b want en=0 data=0000", fifo_wr_en, fifo_wr_data);
        end
        checks++;
        if (s_ready !== 1'b1 || lane_idx !== 2'd0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b lane=%0d cnt=%0d want 1 0 0",
                     s_ready, lane_idx, frame_cnt);
        end
        wr_rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_word();
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (lane_idx !== 2'd2 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL mid_word: lane=%0d en=%b want lane=2 en=0", lane_idx, fifo_wr_en);
        end
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'b1101 || lane_idx !== 2'd0) begin
            failures++;
            $display("FAIL full_word: en=%b data=%b lane=%0d want en=1 data=1101 lane=0",
                     fifo_wr_en, fifo_wr_data, lane_idx);
        end
        step();
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL full_word_after: en=%b cnt=%0d want en=0 cnt=0", fifo_wr_en, frame_cnt);
        end
    endtask

    task automatic test_last_pad();
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b1, 1'b0);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'b0111 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL last_pad: en=%b data=%b cnt=%0d want en=1 data=0111 cnt=0",
                     fifo_wr_en, fifo_wr_data, frame_cnt);
        end
        step();
        #1;
        checks++;
        if (frame_cnt !== 16'd1 || fifo_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL last_cnt: cnt=%0d en=%b want cnt=1 en=0", frame_cnt, fifo_wr_en);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] beats;
        logic [3:0] writes[$];
        int idx = 0;
        int acc_full = 0;
        beats = 8'b0110_0001;  // bit i is beat i
        for (int cyc = 0; cyc < 20; cyc++) begin
            fifo_full = (cyc < 8);
            s_valid   = (idx < 8);
            s_data    = (idx < 8) ? beats[idx] : 1'b0;
            #1;
            if (cyc == 7) begin
                checks++;
                if (s_ready !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_wr_data !== 4'b0001) begin
                    failures++;
                    $display("FAIL held_word: ready=%b en=%b data=%b want 0 0 0001",
                             s_ready, fifo_wr_en, fifo_wr_data);
                end
            end
            if (fifo_wr_en) writes.push_back(fifo_wr_data);
            if (s_valid && s_ready) begin
                idx++;
                if (fifo_full) acc_full++;
            end
            step();
        end
        idle_inputs();
        fifo_full = 1'b0;
        checks++;
        if (acc_full != 4) begin
            failures++;
            $display("FAIL accepted_while_full: got=%0d want=4", acc_full);
        end
        checks++;
        if (writes.size() != 2) begin
            failures++;
            $display("FAIL bp_write_count: got=%0d want=2", writes.size());
        end else begin
            checks++;
            if (writes[0] !== 4'b0001 || writes[1] !== 4'b0110) begin
                failures++;
                $display("FAIL bp_order: got=%b,%b want=0001,0110", writes[0], writes[1]);
            end
        end
        checks++;
        if (frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL bp_cnt: cnt=%0d want=1", frame_cnt);
        end
    endtask

    task automatic test_flush();
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'b0001 || lane_idx !== 2'd0) begin
            failures++;
            $display("FAIL flush_word: en=%b data=%b lane=%0d want en=1 data=0001 lane=0",
                     fifo_wr_en, fifo_wr_data, lane_idx);
        end
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || lane_idx !== 2'd0 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL flush_noop: en=%b lane=%0d cnt=%0d want en=0 lane=0 cnt=1",
                     fifo_wr_en, lane_idx, frame_cnt);
        end
    endtask

    task automatic test_last_flush_same_cycle();
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'b1000) begin
            failures++;
            $display("FAIL last_flush_word: en=%b data=%b want en=1 data=1000",
                     fifo_wr_en, fifo_wr_data);
        end
        step();
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || frame_cnt !== 16'd2) begin
            failures++;
            $display("FAIL last_flush_once: en=%b cnt=%0d want en=0 cnt=2", fifo_wr_en, frame_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        // Held word under a full FIFO is dropped by reset.
        fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(1'b1, 1'b0, 1'b0);
        wr_rst_n = 1'b0;
        #1;
        checks++;
        if (fifo_wr_en !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_held: en=%b ready=%b cnt=%0d want 0 1 0",
                     fifo_wr_en, s_ready, frame_cnt);
        end
        step();
        wr_rst_n  = 1'b1;
        fifo_full = 1'b0;
        step();
        // Partial word at lane 2 is dropped by reset.
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        wr_rst_n = 1'b0;
        #1;
        checks++;
        if (lane_idx !== 2'd0 || fifo_wr_en !== 1'b0 || s_ready !== 1'b1 || frame_cnt !== 16'd0)
        begin
            failures++;
            $display("FAIL reset_partial: lane=%0d en=%b ready=%b cnt=%0d want 0 0 1 0",
                     lane_idx, fifo_wr_en, s_ready, frame_cnt);
        end
        step();
        wr_rst_n = 1'b1;
        step();
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b0, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 4'b1010) begin
            failures++;
            $display("FAIL post_reset_word: en=%b data=%b want en=1 data=1010",
                     fifo_wr_en, fifo_wr_data);
        end
        step();
    endtask

    initial begin
        wr_rst_n  = 1'b0;
        fifo_full = 1'b0;
        idle_inputs();
        @(negedge wr_clk);
        test_reset();
        test_full_word();
        test_last_pad();
        test_backpressure();
        test_flush();
        test_last_flush_same_cycle();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_wr_packer.md
Name: fifo_wr_packer

Overview:
Write-side width packer that sits directly upstream of the dual-clock FIFO, entirely in the wr_clk domain. It accepts a narrow valid/ready beat stream and assembles RATIO beats, LSB-lane first, into one DATA_WIDTH word. It pushes each word into the FIFO write port, obeying the FIFO full flag. Partial words are closed early on s_last or flush, with unfilled lanes padded.

Parameters:
IN_WIDTH, 1, width of one input beat
RATIO, 4, beats per FIFO word (>=2); DATA_WIDTH = IN_WIDTH*RATIO (localparam, 4 by default, matching the FIFO default)
PAD_BIT, 1'b0, value replicated into unfilled lanes of a partial word
CNT_WIDTH, 16, width of frame_cnt

Ports:
wr_clk  input  1  write-domain clock
wr_rst_n  input  1  asynchronous active-low reset
s_valid  input  1  input beat valid
s_ready  output  1  input beat accepted when s_valid && s_ready
s_data  input  IN_WIDTH  input beat
s_last  input  1  beat closes the current frame
flush  input  1  close the current partial word (level, sampled each cycle)
fifo_wr_en  output  1  FIFO write request
fifo_wr_data  output  DATA_WIDTH  FIFO write word
fifo_full  input  1  FIFO full flag (wr_clk domain)
lane_idx  output  log2(RATIO)  next lane to fill (status)
frame_cnt  output  CNT_WIDTH  count of frame-closing words written to the FIFO

Behaviour:
- Reset is wr_rst_n, asynchronous, active-low; clock is wr_clk. On reset: acc=0, lane_idx=0, out_vld=0, out_word=0, out_last=0, frame_cnt=0. Therefore fifo_wr_en=0, fifo_wr_data=0, s_ready=1.
- Datapath: accumulator acc (DATA_WIDTH), lane counter lane_idx, and one output holding slot (out_word, out_last, out_vld).
- fifo_wr_en = out_vld && !fifo_full (combinational). fifo_wr_data = out_word. take = fifo_wr_en. The slot clears on take unless refilled in the same cycle.
- s_ready = !out_vld || take. This is a combinational path from fifo_full and is intentional.
- Accepted beat: s_data is written into lane lane_idx of acc (bits lane_idx*IN_WIDTH +: IN_WIDTH).
- A word closes in a cycle when any of the following holds:
  - an accepted beat has lane_idx==RATIO-1;
  - an accepted beat has s_last=1;
  - flush=1 and (lane_idx>0 or a beat is accepted that cycle).
- On close: out_word = acc with the new beat merged, and lanes above the last filled lane set to PAD_BIT. out_last = s_last of the closing beat. out_vld=1. acc is cleared to 0 and lane_idx to 0.
- Close without an accepted beat (flush only) requires a free slot (!out_vld || take). Otherwise flush waits, and acc and lane_idx hold.
- Otherwise an accepted beat increments lane_idx, with no wrap beyond RATIO-1.
- Latency: the closing beat accepted in cycle N gives fifo_wr_en=1 in cycle N+1 if fifo_full=0.
- Throughput: one beat per cycle while the FIFO is not full. A word is written every RATIO cycles with no bubbles, because the slot frees and refills in the same cycle.
- fifo_full=1: out_vld holds and the word is stable. s_ready=0 whenever out_vld=1. No beat is lost or duplicated.
- Simultaneous events:
  - s_last on lane RATIO-1 produces one word, not two.
  - flush together with s_last produces one word.
  - flush with lane_idx==0 and no accepted beat is a no-op.
- frame_cnt increments by 1 on take when out_last=1. It wraps modulo 2^CNT_WIDTH.
- Reset mid-operation discards the partial acc and any held word. No FIFO write occurs in the reset cycle.

Test Plan:
- Stream beats 1,0,1,1 (IN_WIDTH=1, RATIO=4), fifo_full=0 -> one cycle after the 4th accept: fifo_wr_en=1, fifo_wr_data=4'b1101, lane_idx=0.
- 3 beats 1,1,1 with s_last on the 3rd -> fifo_wr_data=4'b0111 (PAD_BIT=0), frame_cnt 0->1 on the write cycle.
- fifo_full=1 before a word completes, stream 8 beats -> the first word is held stable, s_ready=0, and exactly 4 beats are accepted until full drops. Then 2 writes occur in order with no loss.
- Two beats 1,0 then flush with s_valid=0 -> fifo_wr_data=4'b0001 the cycle after flush. A second flush at lane 0 produces no write.
- s_last on lane 3 with flush=1 the same cycle -> exactly one write, frame_cnt +1.
- Assert wr_rst_n=0 at lane_idx=2 with a held word -> fifo_wr_en=0 immediately, lane_idx=0, frame_cnt=0, s_ready=1. The next 4 beats form a clean word.
